// File: rtl/vga_pkg.sv
// Shared 800x600@60 (40 MHz) timing constants and the output-stage state type.
package vga_pkg;

  localparam int H_SYNC_W   = 128;
  localparam int H_BACK     = 88;
  localparam int H_ACTIVE   = 800;
  localparam int H_FRONT    = 40;
  localparam int H_TOTAL    = H_SYNC_W + H_BACK + H_ACTIVE + H_FRONT;

  localparam int V_SYNC_W   = 4;
  localparam int V_BACK     = 23;
  localparam int V_ACTIVE   = 600;
  localparam int V_FRONT    = 1;
  localparam int V_TOTAL    = V_SYNC_W + V_BACK + V_ACTIVE + V_FRONT;

  // Counters from vga_sync put the first visible pixel one past sync + back porch.
  localparam int H_ACT_START_DEF = H_SYNC_W + H_BACK + 1;
  localparam int H_ACT_END_DEF   = H_ACT_START_DEF + H_ACTIVE - 1;
  localparam int V_ACT_START_DEF = V_SYNC_W + V_BACK + 1;
  localparam int V_ACT_END_DEF   = V_ACT_START_DEF + V_ACTIVE - 1;

  localparam int BAR_W_DEF = H_ACTIVE / 8;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/vga_delay_line.sv
// Reset-valued shift register of DEPTH stages, WIDTH bits each; dout is the oldest stage.
module vga_delay_line #(
  parameter int               WIDTH   = 24,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int TW = WIDTH * DEPTH;

  logic [TW-1:0] taps_q;
  logic [TW-1:0] taps_d;

  always_comb begin
    taps_d            = taps_q << WIDTH;
    taps_d[WIDTH-1:0] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q <= {DEPTH{RST_VAL}};
    end else begin
      taps_q <= taps_d;
    end
  end

  assign dout = taps_q[TW-1 -: WIDTH];

endmodule

// File: rtl/vga_out_stage.sv
// VGA pad stage: realigns syncs with the pixel pipeline, blanks rgb, starts/stops on frame edges.
// Define VGA_TEST_PATTERN_EN to add pattern_sel and an 8-bar colour generator that replaces rgb_in.
module vga_out_stage
  import vga_pkg::*;
#(
  parameter int DELAY_N     = 2,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
`ifdef VGA_TEST_PATTERN_EN
  parameter int BAR_W       = BAR_W_DEF,
`endif
  parameter int V_ACT_END   = V_ACT_END_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [10:0] c1,
  input  logic [10:0] c2,
  input  logic [2:0]  rgb_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [2:0]  vga_rgb,
  output logic        vga_de,
  output logic        locked,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] HA_S = 11'(H_ACT_START);
  localparam logic [10:0] HA_E = 11'(H_ACT_END);
  localparam logic [10:0] VA_S = 11'(V_ACT_START);
  localparam logic [10:0] VA_E = 11'(V_ACT_END);

  logic [23:0] dly_out;
  logic        hs_d, vs_d;
  logic [10:0] c1_d, c2_d;

  vga_delay_line #(
    .WIDTH  (24),
    .DEPTH  (DELAY_N),
    .RST_VAL({1'b1, 1'b1, 22'd0})
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .din ({hsync_in, vsync_in, c1, c2}),
    .dout(dly_out)
  );

  assign {hs_d, vs_d, c1_d, c2_d} = dly_out;

  state_t      state_q, state_d;
  logic        vs_prev_q, vs_prev_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        hs_out_q, hs_out_d;
  logic        vs_out_q, vs_out_d;
  logic        de_q, de_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        fe, act;
  logic [2:0]  pix;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] HA_PRE   = 11'(H_ACT_START - 1);
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

  logic [2:0]  bar_q, bar_d;
  logic [10:0] px_q, px_d;

  // bar_q holds k/BAR_W for the pixel currently at c1_d (pixels before it are counted).
  always_comb begin
    bar_d = bar_q;
    px_d  = px_q;
    if (c1_d == HA_PRE) begin
      bar_d = 3'd0;
      px_d  = 11'd0;
    end else if (act) begin
      if (px_q == BAR_LAST) begin
        px_d  = 11'd0;
        bar_d = bar_q + 3'd1;
      end else begin
        px_d = px_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_q <= 3'd0;
      px_q  <= 11'd0;
    end else begin
      bar_q <= bar_d;
      px_q  <= px_d;
    end
  end
`endif

  always_comb begin
    act       = (c1_d >= HA_S) && (c1_d <= HA_E) && (c2_d >= VA_S) && (c2_d <= VA_E);
    fe        = vs_prev_q & ~vs_d;
    vs_prev_d = vs_d;

    state_d = state_q;
    case (state_q)
      S_WAIT:  if (fe && en)  state_d = S_RUN;
      S_RUN:   if (fe && !en) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase

    frame_cnt_d = frame_cnt_q;
    if (fe && (state_q == S_RUN || state_d == S_RUN)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    pix = act ? rgb_in : 3'd0;
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel && act) pix = bar_q;
`endif

    // Pads follow the next state so entry and exit both land exactly on the frame edge.
    hs_out_d = 1'b1;
    vs_out_d = 1'b1;
    rgb_d    = 3'd0;
    de_d     = 1'b0;
    if (state_d == S_RUN) begin
      hs_out_d = hs_d;
      vs_out_d = vs_d;
      rgb_d    = pix;
      de_d     = act;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT;
      vs_prev_q   <= 1'b1;
      frame_cnt_q <= 16'd0;
      hs_out_q    <= 1'b1;
      vs_out_q    <= 1'b1;
      rgb_q       <= 3'd0;
      de_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_prev_q   <= vs_prev_d;
      frame_cnt_q <= frame_cnt_d;
      hs_out_q    <= hs_out_d;
      vs_out_q    <= vs_out_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
    end
  end

  assign vga_hsync = hs_out_q;
  assign vga_vsync = vs_out_q;
  assign vga_rgb   = rgb_q;
  assign vga_de    = de_q;
  assign locked    = (state_q == S_RUN);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// Bench for vga_out_stage on a shrunken raster; a cycle model pushes expected pad values per drive.
module tb_vga_out_stage;

  localparam int DN       = 2;
  localparam int H_TOT    = 40;
  localparam int HS_LO    = 32;
  localparam int HS_HI    = 35;
  localparam int HA_S     = 8;
  localparam int HA_E     = 23;
  localparam int V_TOT    = 14;
  localparam int VS_LINES = 2;
  localparam int VA_S     = 3;
  localparam int VA_E     = 10;
  localparam int BAR_W    = 2;
  localparam int FRAME    = H_TOT * V_TOT;
  localparam int DE_PER_FRAME = (HA_E - HA_S + 1) * (VA_E - VA_S + 1);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [10:0] c1;
    logic [10:0] c2;
  } sync_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
    logic        de;
    logic        locked;
    logic [15:0] cnt;
  } pads_t;

  localparam pads_t IDLE = '{hs: 1'b1, vs: 1'b1, rgb: 3'd0, de: 1'b0, locked: 1'b0, cnt: 16'd0};

  logic        clk = 1'b0;
  logic        rst, en, hsync_in, vsync_in;
  logic [10:0] c1, c2;
  logic [2:0]  rgb_in;
  logic        vga_hsync, vga_vsync, vga_de, locked;
  logic [2:0]  vga_rgb;
  logic [15:0] frame_cnt;
`ifdef VGA_TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  vga_out_stage #(
    .DELAY_N    (DN),
    .H_ACT_START(HA_S),
    .H_ACT_END  (HA_E),
    .V_ACT_START(VA_S),
`ifdef VGA_TEST_PATTERN_EN
    .BAR_W      (BAR_W),
`endif
    .V_ACT_END  (VA_E)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .c1       (c1),
    .c2       (c2),
    .rgb_in   (rgb_in),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_rgb  (vga_rgb),
    .vga_de   (vga_de),
    .locked   (locked),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  sync_t       dq[$];
  pads_t       exp_q[$];
  logic        m_run, m_prev_vs;
  logic [15:0] m_cnt;
  logic        g_prev_vs = 1'b1;
  int          gc1 = 0;
  int          gc2 = 5;
  int          tidx = 0;
  int          fall_t = -1;
  int          rgb_mode = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic pads_t get_pads();
    pads_t p;
    p.hs     = vga_hsync;
    p.vs     = vga_vsync;
    p.rgb    = vga_rgb;
    p.de     = vga_de;
    p.locked = locked;
    p.cnt    = frame_cnt;
    return p;
  endfunction

  task automatic model_reset();
    dq.delete();
    exp_q.delete();
    for (int i = 0; i < DN; i++) dq.push_back('{hs: 1'b1, vs: 1'b1, c1: 11'd0, c2: 11'd0});
    m_run     = 1'b0;
    m_prev_vs = 1'b1;
    m_cnt     = 16'd0;
  endtask

  // Drive one raster position, predict the pads for the coming edge, then step past that edge.
  task automatic tick();
    sync_t      cur, dly;
    logic       fe, act, nxt;
    logic [2:0] px;
    pads_t      e;
    tidx++;
    cur.hs = !(gc1 >= HS_LO && gc1 <= HS_HI);
    cur.vs = !(gc2 < VS_LINES);
    cur.c1 = 11'(gc1);
    cur.c2 = 11'(gc2);
    if (g_prev_vs && !cur.vs) fall_t = tidx;
    g_prev_vs = cur.vs;
    dq.push_back(cur);
    dly = dq.pop_front();
    act = (int'(dly.c1) >= HA_S) && (int'(dly.c1) <= HA_E) &&
          (int'(dly.c2) >= VA_S) && (int'(dly.c2) <= VA_E);
    case (rgb_mode)
      1:       px = (int'(dly.c1) == HA_S && int'(dly.c2) == VA_S) ? 3'b101 : 3'b000;
      2:       px = 3'b111;
      3:       px = 3'($urandom_range(0, 7));
      default: px = 3'b000;
    endcase
    hsync_in = cur.hs;
    vsync_in = cur.vs;
    c1       = cur.c1;
    c2       = cur.c2;
    rgb_in   = px;

    fe        = m_prev_vs && !dly.vs;
    m_prev_vs = dly.vs;
    nxt       = m_run;
    if (fe) begin
      if (!m_run && en)      nxt = 1'b1;
      else if (m_run && !en) nxt = 1'b0;
      if (m_run || nxt) m_cnt = m_cnt + 16'd1;
    end
    m_run    = nxt;
    e        = IDLE;
    e.locked = nxt;
    e.cnt    = m_cnt;
    if (nxt) begin
      e.hs  = dly.hs;
      e.vs  = dly.vs;
      e.de  = act;
      e.rgb = act ? px : 3'd0;
`ifdef VGA_TEST_PATTERN_EN
      if (act && pattern_sel) e.rgb = 3'((int'(dly.c1) - HA_S) / BAR_W);
`endif
    end
    exp_q.push_back(e);

    gc1++;
    if (gc1 == H_TOT) begin
      gc1 = 0;
      gc2 = (gc2 == V_TOT - 1) ? 0 : gc2 + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pads_t got;
    rst = 1'b1; en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    c1 = 11'd0; c2 = 11'd0; rgb_in = 3'd0;
    #1;
    got = get_pads();
    checks++;
    if (got !== IDLE) begin
      errors++;
      $display("FAIL reset_initial got=%h want=%h", got, IDLE);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_lock();
    pads_t got, want;
    int    lock_t = -1;
    en = 1'b1;
    rgb_mode = 0;
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 3 * FRAME && lock_t < 0; i++) begin
      tick();
      got = get_pads(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pads_lock t=%0d got=%h want=%h", tidx, got, want); end
      if (locked === 1'b1) lock_t = tidx;
    end
    // A fall sampled at edge k reaches the pads at edge k+DN, the (DN+1)th clock.
    checks++;
    if (lock_t < 0 || fall_t < 0 || lock_t - fall_t != DN) begin
      errors++;
      $display("FAIL lock_latency got=%0d want=%0d (fall_t=%0d lock_t=%0d)", lock_t - fall_t, DN, fall_t, lock_t);
    end
    checks++;
    if (vga_vsync !== 1'b0 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lock_state got vsync=%b cnt=%0d want vsync=0 cnt=1", vga_vsync, frame_cnt);
    end
  endtask

  task automatic test_first_pixel();
    pads_t      got, want;
    logic [2:0] prev_rgb;
    logic       found = 1'b0;
    rgb_mode = 1;
    prev_rgb = vga_rgb;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      prev_rgb = vga_rgb;
      tick();
      got = get_pads(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pads_first t=%0d got=%h want=%h", tidx, got, want); end
      if (vga_de === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || vga_rgb !== 3'b101 || prev_rgb !== 3'b000) begin
      errors++;
      $display("FAIL first_pixel got rgb=%b prev=%b found=%b want rgb=101 prev=000", vga_rgb, prev_rgb, found);
    end
    tick();
    got = get_pads(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL pads_first t=%0d got=%h want=%h", tidx, got, want); end
    checks++;
    if (vga_rgb !== 3'b000 || vga_de !== 1'b1) begin
      errors++;
      $display("FAIL pixel_after got rgb=%b de=%b want rgb=000 de=1", vga_rgb, vga_de);
    end
  endtask

  task automatic test_full_frame();
    pads_t got, want;
    logic  prev_vs;
    int    falls = 0, de_cnt = 0, bad = 0;
    rgb_mode = 2;
    prev_vs  = vga_vsync;
    for (int i = 0; i < 3 * FRAME && falls < 2; i++) begin
      tick();
      got = get_pads(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pads_frame t=%0d got=%h want=%h", tidx, got, want); end
      if (prev_vs === 1'b1 && vga_vsync === 1'b0) falls++;
      if (falls == 1) begin
        if (vga_de === 1'b1) de_cnt++;
        if (vga_rgb !== (vga_de ? 3'b111 : 3'b000)) bad++;
      end
      prev_vs = vga_vsync;
    end
    checks++;
    if (falls != 2 || de_cnt != DE_PER_FRAME) begin
      errors++;
      $display("FAIL de_per_frame got=%0d want=%0d (frame edges seen %0d)", de_cnt, DE_PER_FRAME, falls);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rgb_iff_de got=%0d bad cycles want=0", bad);
    end
  endtask

  task automatic test_reset_mid();
    pads_t got, want;
    rgb_mode = 3;
    for (int i = 0; i < FRAME / 3; i++) begin
      tick();
      got = get_pads(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pads_mid t=%0d got=%h want=%h", tidx, got, want); end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL locked_before_rst got=%b want=1", locked); end
    rst = 1'b1;
    #1;
    got = get_pads();
    checks++;
    if (got !== IDLE) begin errors++; $display("FAIL reset_async got=%h want=%h", got, IDLE); end
    repeat (2) @(posedge clk);
    #1;
    got = get_pads();
    checks++;
    if (got !== IDLE) begin errors++; $display("FAIL reset_held got=%h want=%h", got, IDLE); end
    en = 1'b1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_drop_en();
    pads_t got, want;
    int    n = 0;
    rgb_mode = 3;
    for (int i = 0; i < 4 * FRAME && frame_cnt !== 16'd2; i++) begin
      tick();
      got = get_pads(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pads_drop t=%0d got=%h want=%h", tidx, got, want); end
    end
    checks++;
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL reach_frame2 got=%0d want=2", frame_cnt); end
    // A short en glitch inside the frame, then a real drop; only the level at the edge counts.
    for (int i = 0; i < FRAME / 2; i++) begin
      if (i == FRAME / 8) en = 1'b0;
      if (i == FRAME / 8 + 10) en = 1'b1;
      if (i == FRAME / 4) en = 1'b0;
      tick();
      got = get_pads(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pads_drop t=%0d got=%h want=%h", tidx, got, want); end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL run_to_frame_end got locked=%b want=1", locked); end
    for (int i = 0; i < 2 * FRAME && locked !== 1'b0; i++) begin
      tick(); n++;
      got = get_pads(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pads_drop t=%0d got=%h want=%h", tidx, got, want); end
    end
    checks++;
    if (locked !== 1'b0 || frame_cnt !== 16'd3 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1) begin
      errors++;
      $display("FAIL unlock got locked=%b cnt=%0d hs=%b vs=%b after %0d clocks want locked=0 cnt=3 hs=1 vs=1",
               locked, frame_cnt, vga_hsync, vga_vsync, n);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      got = get_pads(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pads_idle t=%0d got=%h want=%h", tidx, got, want); end
    end
    checks++;
    if (frame_cnt !== 16'd3 || locked !== 1'b0) begin
      errors++;
      $display("FAIL stay_idle got cnt=%0d locked=%b want cnt=3 locked=0", frame_cnt, locked);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    pads_t got, want;
    en = 1'b1;
    pattern_sel = 1'b1;
    rgb_mode = 3;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      got = get_pads(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pads_pattern t=%0d got=%h want=%h", tidx, got, want); end
    end
    pattern_sel = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_first_pixel();
    test_full_frame();
    test_reset_mid();
    test_drop_en();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
